// File: rtl/id.sv
// id: RV32I instruction decoder; decodes combinationally and registers every
// output, so decoded fields appear one clock after inst/inst_addr.
module id (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output logic [4:0]  rs1_raddr_o,
    output logic [4:0]  rs2_raddr_o,
    output logic [4:0]  rd_waddr_o,
    output logic [11:0] csr_raddr_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] imm_o,
    output logic [1:0]  op1_sel_o,
    output logic [1:0]  op2_sel_o,
    output logic [3:0]  alu_sel_o,
    output logic [2:0]  br_sel_o,
    output logic [2:0]  wb_sel_o,
    output logic [1:0]  mem_rw_o,
    output logic [3:0]  byte_sel_o,
    output logic        un_sign_o
);
    localparam logic [6:0] opc_opimm = 7'b0010011, opc_op = 7'b0110011, opc_load = 7'b0000011,
                           opc_store = 7'b0100011, opc_branch = 7'b1100011, opc_lui = 7'b0110111,
                           opc_auipc = 7'b0010111, opc_jal = 7'b1101111, opc_jalr = 7'b1100111,
                           opc_system = 7'b1110011;
    logic [2:0]   w_f3;
    logic [31:0]  w_imm;
    logic [11:0]  w_csr;
    logic [4:0]   w_rd;
    logic [1:0]   w_op1, w_op2, w_mem;
    logic [3:0]   w_alu, w_bs;
    logic [2:0]   w_br, w_wb;
    logic         w_uns;
    logic [155:0] w_dec, r_dec;
    assign w_f3 = inst[14:12];
    // alt selects SUB for f3=0 and SRA for f3=5
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? 4'd1 : 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd4;
            3'd4:    return 4'd5;
            3'd5:    return alt ? 4'd7 : 4'd6;
            3'd6:    return 4'd8;
            default: return 4'd9;
        endcase
    endfunction
    always_comb begin
        w_imm = '0;
        w_csr = '0;
        w_op1 = '0;
        w_op2 = '0;
        w_alu = '0;
        w_br  = '0;
        w_wb  = '0;
        w_mem = '0;
        w_bs  = '0;
        w_uns = 1'b0;
        case (inst[6:0])
            opc_opimm: begin
                w_imm = {{20{inst[31]}}, inst[31:20]};
                w_op2 = 2'd1;
                w_alu = alu_of(w_f3, inst[30] && w_f3 == 3'd5);
                w_wb  = 3'd1;
                w_uns = w_f3 == 3'd3;
            end
            opc_op: begin
                w_alu = alu_of(w_f3, inst[30]);
                w_wb  = 3'd1;
                w_uns = w_f3 == 3'd3;
            end
            opc_load: if (w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                w_imm = {{20{inst[31]}}, inst[31:20]};
                w_op2 = 2'd1;
                w_wb  = 3'd2;
                w_mem = 2'd1;
                w_bs  = w_f3[1] ? 4'hF : w_f3[0] ? 4'h3 : 4'h1;
                w_uns = w_f3[2];
            end
            opc_store: if (w_f3 < 3'd3) begin
                w_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                w_op2 = 2'd1;
                w_mem = 2'd2;
                w_bs  = w_f3[1] ? 4'hF : w_f3[0] ? 4'h3 : 4'h1;
            end
            opc_branch: if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
                w_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                w_op1 = 2'd1;
                w_op2 = 2'd1;
                w_br  = w_f3[2] ? (w_f3[0] ? 3'd4 : 3'd3) : (w_f3[0] ? 3'd2 : 3'd1);
                w_uns = w_f3[1];
            end
            opc_lui, opc_auipc: begin
                w_imm = {inst[31:12], 12'b0};
                w_op1 = inst[5] ? 2'd2 : 2'd1;
                w_op2 = 2'd1;
                w_alu = inst[5] ? 4'hA : 4'h0;
                w_wb  = 3'd1;
            end
            opc_jal: begin
                w_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                w_op1 = 2'd1;
                w_op2 = 2'd1;
                w_br  = 3'd5;
                w_wb  = 3'd3;
            end
            opc_jalr: if (w_f3 == 3'd0) begin
                w_imm = {{20{inst[31]}}, inst[31:20]};
                w_op2 = 2'd1;
                w_br  = 3'd6;
                w_wb  = 3'd3;
            end
            // f3 of 0 (ECALL/EBREAK) and 4 (reserved) stay NOP
            opc_system: if (w_f3[1:0] != 2'd0) begin
                w_imm = w_f3[2] ? {27'b0, inst[19:15]} : 32'b0;
                w_csr = inst[31:20];
                w_op1 = w_f3[2] ? 2'd2 : 2'd0;
                w_op2 = 2'd3;
                w_alu = w_f3[1] ? 4'h8 : 4'h0;
                w_wb  = 3'd4;
            end
            default: ;
        endcase
        w_rd = (w_wb != 3'd0) ? inst[11:7] : 5'd0;
    end
    assign w_dec = {inst[19:15], inst[24:20], w_rd, w_csr, w_csr, inst, inst_addr, w_imm,
                    w_op1, w_op2, w_alu, w_br, w_wb, w_mem, w_bs, w_uns};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_dec <= '0;
        else     r_dec <= w_dec;
    end
    assign {rs1_raddr_o, rs2_raddr_o, rd_waddr_o, csr_raddr_o, csr_waddr_o, inst_o, inst_addr_o,
            imm_o, op1_sel_o, op2_sel_o, alu_sel_o, br_sel_o, wb_sel_o, mem_rw_o, byte_sel_o,
            un_sign_o} = r_dec;
endmodule

// File: tb/tb_id.sv
// tb_id: directed decode checks for id with an expected-result queue.
module tb_id;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h00108F93;
    logic [31:0] inst_addr = 32'h0000_0ABC;
    logic [4:0]  rs1_raddr_o, rs2_raddr_o, rd_waddr_o;
    logic [11:0] csr_raddr_o, csr_waddr_o;
    logic [31:0] inst_o, inst_addr_o, imm_o;
    logic [1:0]  op1_sel_o, op2_sel_o, mem_rw_o;
    logic [3:0]  alu_sel_o, byte_sel_o;
    logic [2:0]  br_sel_o, wb_sel_o;
    logic        un_sign_o;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] ins, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] csr;
        logic [31:0] imm;
        logic [1:0]  op1, op2;
        logic [3:0]  alu;
        logic [2:0]  br, wb;
        logic [1:0]  mem;
        logic [3:0]  bs;
        logic        uns;
    } exp_t;
    exp_t sb[$];

    id dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_addr(inst_addr),
        .rs1_raddr_o(rs1_raddr_o), .rs2_raddr_o(rs2_raddr_o), .rd_waddr_o(rd_waddr_o),
        .csr_raddr_o(csr_raddr_o), .csr_waddr_o(csr_waddr_o),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .imm_o(imm_o),
        .op1_sel_o(op1_sel_o), .op2_sel_o(op2_sel_o), .alu_sel_o(alu_sel_o),
        .br_sel_o(br_sel_o), .wb_sel_o(wb_sel_o), .mem_rw_o(mem_rw_o),
        .byte_sel_o(byte_sel_o), .un_sign_o(un_sign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", name, fld, obs, exp);
        end
    endtask

    task automatic zero_chk(input string name);
        logic [155:0] all;
        all = {rs1_raddr_o, rs2_raddr_o, rd_waddr_o, csr_raddr_o, csr_waddr_o, inst_o, inst_addr_o,
               imm_o, op1_sel_o, op2_sel_o, alu_sel_o, br_sel_o, wb_sel_o, mem_rw_o, byte_sel_o,
               un_sign_o};
        checks++;
        assert (all === '0) else begin
            errors++;
            $error("FAIL %s all_outputs observed=%h expected=0", name, all);
        end
    endtask

    task automatic step(input string name, input logic [31:0] i, input logic [31:0] a,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [11:0] csr, input logic [31:0] imm,
                        input logic [1:0] op1, input logic [1:0] op2, input logic [3:0] alu,
                        input logic [2:0] br, input logic [2:0] wb, input logic [1:0] mem,
                        input logic [3:0] bs, input logic uns);
        exp_t e;
        @(negedge clk);
        inst = i;
        inst_addr = a;
        sb.push_back('{i, a, rs1, rs2, rd, csr, imm, op1, op2, alu, br, wb, mem, bs, uns});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", name);
        end else begin
            e = sb.pop_front();
            chk(name, "inst", inst_o, e.ins);
            chk(name, "pc", inst_addr_o, e.pc);
            chk(name, "rs1", 32'(rs1_raddr_o), 32'(e.rs1));
            chk(name, "rs2", 32'(rs2_raddr_o), 32'(e.rs2));
            chk(name, "rd", 32'(rd_waddr_o), 32'(e.rd));
            chk(name, "csr_r", 32'(csr_raddr_o), 32'(e.csr));
            chk(name, "csr_w", 32'(csr_waddr_o), 32'(e.csr));
            chk(name, "imm", imm_o, e.imm);
            chk(name, "op1", 32'(op1_sel_o), 32'(e.op1));
            chk(name, "op2", 32'(op2_sel_o), 32'(e.op2));
            chk(name, "alu", 32'(alu_sel_o), 32'(e.alu));
            chk(name, "br", 32'(br_sel_o), 32'(e.br));
            chk(name, "wb", 32'(wb_sel_o), 32'(e.wb));
            chk(name, "mem", 32'(mem_rw_o), 32'(e.mem));
            chk(name, "bsel", 32'(byte_sel_o), 32'(e.bs));
            chk(name, "uns", 32'(un_sign_o), 32'(e.uns));
        end
    endtask

    initial begin
        #1 zero_chk("reset_start");
        repeat (2) @(posedge clk);
        #1 zero_chk("reset_held");
        @(negedge clk) rst = 1'b0;
        //    name      inst          pc            rs1 rs2 rd  csr      imm           op1 op2 alu  br  wb  mem bs  uns
        step("addi",   32'h00108F93, 32'h1000, 1, 1, 31, 12'h000, 32'h00000001, 0, 1, 4'h0, 0, 1, 0, 4'h0, 0);
        step("bge",    32'hFE20D063, 32'h1004, 1, 2, 0,  12'h000, 32'hFFFFF7E0, 1, 1, 4'h0, 4, 0, 0, 4'h0, 0);
        step("lh",     32'h00309F83, 32'h1008, 1, 3, 31, 12'h000, 32'h00000003, 0, 1, 4'h0, 0, 2, 1, 4'h3, 0);
        step("sb",     32'h80208223, 32'h100C, 1, 2, 0,  12'h000, 32'hFFFFF804, 0, 1, 4'h0, 0, 0, 2, 4'h1, 0);
        step("lui",    32'h00005FB7, 32'h1010, 0, 0, 31, 12'h000, 32'h00005000, 2, 1, 4'hA, 0, 1, 0, 4'h0, 0);
        step("auipc",  32'h00006F97, 32'h1014, 0, 0, 31, 12'h000, 32'h00006000, 1, 1, 4'h0, 0, 1, 0, 4'h0, 0);
        step("jal",    32'h008000EF, 32'h1018, 0, 8, 1,  12'h000, 32'h00000008, 1, 1, 4'h0, 5, 3, 0, 4'h0, 0);
        step("sub",    32'h402081B3, 32'h101C, 1, 2, 3,  12'h000, 32'h00000000, 0, 0, 4'h1, 0, 1, 0, 4'h0, 0);
        step("sltu",   32'h007332B3, 32'h1020, 6, 7, 5,  12'h000, 32'h00000000, 0, 0, 4'h4, 0, 1, 0, 4'h0, 1);
        step("srai",   32'h40325213, 32'h1024, 4, 3, 4,  12'h000, 32'h00000403, 0, 1, 4'h7, 0, 1, 0, 4'h0, 0);
        step("lbu",    32'h0000C103, 32'h1028, 1, 0, 2,  12'h000, 32'h00000000, 0, 1, 4'h0, 0, 2, 1, 4'h1, 1);
        step("bltu",   32'h0020E863, 32'h102C, 1, 2, 0,  12'h000, 32'h00000010, 1, 1, 4'h0, 3, 0, 0, 4'h0, 1);
        step("csrrs",  32'h3000A2F3, 32'h1030, 1, 0, 5,  12'h300, 32'h00000000, 0, 3, 4'h8, 0, 4, 0, 4'h0, 0);
        step("csrrci", 32'h3054F373, 32'h1034, 9, 5, 6,  12'h305, 32'h00000009, 2, 3, 4'h8, 0, 4, 0, 4'h0, 0);
        step("ecall",  32'h00000073, 32'h1038, 0, 0, 0,  12'h000, 32'h00000000, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
        step("fence",  32'h0FF0000F, 32'h103C, 0, 31, 0, 12'h000, 32'h00000000, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
        step("jalr",   32'h80708FE7, 32'h2000, 1, 7, 31, 12'h000, 32'hFFFFF807, 0, 1, 4'h0, 6, 3, 0, 4'h0, 0);
        #2 rst = 1'b1;
        #1 zero_chk("async_rst");
        @(posedge clk);
        #1 zero_chk("rst_mid_held");
        @(negedge clk) rst = 1'b0;
        step("addi_post_rst", 32'h00108F93, 32'h3000, 1, 1, 31, 12'h000, 32'h00000001, 0, 1, 4'h0, 0, 1, 0, 4'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id.md
ID -- requirements
Module: id

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 inst  in  32  instruction word; inst_addr  in  32  PC of inst.
REQ-004 rs1_raddr_o  out  5  inst[19:15]; rs2_raddr_o  out  5  inst[24:20]; rd_waddr_o  out  5  inst[11:7].
REQ-005 csr_raddr_o / csr_waddr_o  out  12  CSR address inst[31:20], CSR ops only, else 0.
REQ-006 inst_o  out  32  and inst_addr_o  out  32: registered copies of inst and inst_addr.
REQ-007 imm_o  out  32  sign-extended immediate.
REQ-008 op1_sel_o  out  2: 00 rs1, 01 PC, 10 zero, 11 reserved.
REQ-009 op2_sel_o  out  2: 00 rs2, 01 imm, 10 constant 4, 11 CSR data.
REQ-010 alu_sel_o  out  4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, A pass-op2; B-F reserved.
REQ-011 br_sel_o  out  3: 000 none, 001 EQ, 010 NE, 011 LT, 100 GE, 101 JAL, 110 JALR, 111 reserved.
REQ-012 wb_sel_o  out  3: 000 no writeback, 001 ALU, 010 memory, 011 PC+4, 100 CSR.
REQ-013 mem_rw_o  out  2: 00 none, 01 read, 10 write; byte_sel_o  out  4: 0000 none, 0001 byte, 0011 half, 1111 word.
REQ-014 un_sign_o  out  1: 1 = unsigned compare/zero-extending load.

Function
REQ-015 Decode SHALL be combinational from inst/inst_addr; all outputs SHALL be registered on rising clk (1-cycle latency).
REQ-016 Immediates SHALL follow RV32I: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; I/S/B/J sign-extended from inst[31].
REQ-017 OP-IMM (0010011): op1 rs1, op2 imm, alu per funct3 (SRAI when inst[30]=1), wb ALU; SLTIU un_sign 1.
REQ-018 OP (0110011): op1 rs1, op2 rs2, alu per funct3/inst[30] (SUB, SRA), wb ALU; SLTU un_sign 1.
REQ-019 LOAD (0000011): op1 rs1, op2 imm, ADD, mem read, wb memory; LB/LBU byte, LH/LHU half, LW word; LBU/LHU un_sign 1.
REQ-020 STORE (0100011): op1 rs1, op2 imm, ADD, mem write, wb none, byte_sel per funct3 (SB/SH/SW).
REQ-021 BRANCH (1100011): op1 PC, op2 imm, ADD (target), wb none; BEQ EQ, BNE NE, BLT/BLTU LT, BGE/BGEU GE; BLTU/BGEU un_sign 1.
REQ-022 LUI: op1 zero, op2 imm, pass-op2, wb ALU; AUIPC: op1 PC, op2 imm, ADD, wb ALU.
REQ-023 JAL: op1 PC, op2 imm, ADD, br JAL, wb PC+4; JALR: op1 rs1, op2 imm, ADD, br JALR, wb PC+4.
REQ-024 SYSTEM CSRRW/S/C(I) (1110011, funct3!=0): csr addresses set, op1 rs1 (imm variants: zero and imm_o = zero-extended inst[19:15]), op2 CSR data, alu pass-op1 via OR for S/C family, wb CSR.
REQ-025 Unsupported/illegal opcodes, FENCE, ECALL/EBREAK SHALL decode as NOP: all control fields 0, rd 0, imm 0; inst_o/inst_addr_o still pass through.
REQ-026 Register-address fields SHALL pass through for every format; unused ones need not be zeroed except rd_waddr_o=0 when wb none.

Reset
REQ-027 While rst=1, all outputs SHALL be 0 immediately (asynchronous) and remain 0; first decode appears one clk edge after rst deasserts.

Verification
REQ-028 addi x31,x1,1 (0x00108F93) -> rs1 1, rd 31, imm 0x00000001, op1 00, op2 01, alu ADD, wb 001, mem 00.
REQ-029 bge x1,x2,-2080 (0xFE20D063) -> rs1 1, rs2 2, imm 0xFFFFF7E0, op1 01, br 100, wb 000, un_sign 0.
REQ-030 lh x31,3(x1) (0x00309F83) -> imm 0x00000003, mem 01, byte_sel 0011, wb 010, un_sign 0.
REQ-031 sb x2,-2044(x1) (0x80208223) -> imm 0xFFFFF804, mem 10, byte_sel 0001, wb 000.
REQ-032 lui x31,5 (0x00005FB7) -> imm 0x00005000, op1 10, alu pass-op2; auipc x31,6 (0x00006F97) -> imm 0x00006000, op1 01, ADD.
REQ-033 jalr x31,-2041(x1) (0x80708FE7) -> imm 0xFFFFF807, br 110, wb 011; assert rst mid-stream -> all outputs 0 without clock edge.
